// File: rtl/erlist_fetch_pkg.sv
// Shared constants and types for the Earthrise command fetcher.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package erlist_fetch_pkg;

  // Default geometry of the command list and fetch buffer
  localparam int WORD_W = 32;
  localparam int ADDR_W = 9;
  localparam int OP_W   = 4;
  localparam int FIFO_D = 4;

  // Opcode that terminates a command list; never forwarded to the decoder
  localparam logic [3:0] OP_END = 4'hF;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ABORT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/erlist_fetch_fifo.sv
// First-word-fall-through FIFO holding fetched command words.
// Latency: a pushed word is visible on dout the following cycle.
// Backpressure: upstream must not push while full (checked); flush empties it in one cycle.
module erlist_fetch_fifo #(
  parameter int WORD  = 32,
  parameter int FIFOD = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WORD-1:0]          din,
  input  logic                     pop,
  output logic [WORD-1:0]          dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(FIFOD):0]   count,
  input  logic                     flush
);

  localparam int AW = $clog2(FIFOD);
  localparam int CW = AW + 1;

  logic [WORD-1:0] mem [FIFOD];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFOD));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr];

  // Storage array carries no reset; validity is tracked by count alone
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; flush discards everything at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full && !flush));

endmodule

// File: rtl/erlist_fetch.sv
// Walks the Earthrise command list from start_addr and streams words to the decoder until END or abort.
// Latency: RAM read 2 cycles; first cmd_valid 3 cycles after start is accepted, then one word per cycle.
// Backpressure: cmd_ready low stalls cmd; reads issue only while in-flight plus queued words fit in the FIFO.
module erlist_fetch
  import erlist_fetch_pkg::*;
#(
  parameter int WORD  = WORD_W,
  parameter int ADDRW = ADDR_W,
  parameter int OPW   = OP_W,
  parameter int FIFOD = FIFO_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ADDRW-1:0] start_addr,
  input  logic             abort,
  output logic [ADDRW-1:0] addr_er,
  input  logic [WORD-1:0]  din_er,
  output logic [WORD-1:0]  cmd,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic             busy,
  output logic             done
);

  localparam logic [OPW-1:0] OP_END_L = OPW'(OP_END);

  fetch_state_t          state;
  logic [1:0]            pipe;        // [0] = read issued last cycle, [1] = read landing on din_er now
  logic [1:0]            inflight;
  logic [$clog2(FIFOD):0] fifo_count;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  end_seen;
  logic                  land;
  logic                  land_end;
  logic                  credit_ok;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  flush;

  assign inflight  = {1'b0, pipe[0]} + {1'b0, pipe[1]};
  assign land      = pipe[1];
  assign land_end  = land && (din_er[WORD-1 -: OPW] == OP_END_L);
  // Reserve a FIFO slot for every read before it is issued so a landing word always fits
  assign credit_ok = (int'(inflight) + int'(fifo_count) + 1) <= FIFOD;
  // The cycle END lands no further read goes out; abort overrides everything
  assign issue     = (state == ST_FETCH) && !end_seen && !abort && !land_end && credit_ok;
  assign push      = (state == ST_FETCH) && !abort && land && !land_end;
  assign flush     = abort && (state != ST_IDLE);
  assign cmd_valid = !fifo_empty;
  assign pop       = cmd_valid && cmd_ready;

  erlist_fetch_fifo #(
    .WORD  (WORD),
    .FIFOD (FIFOD)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (din_er),
    .pop   (pop),
    .dout  (cmd),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count),
    .flush (flush)
  );

  // Track issued reads through the 2-cycle RAM latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pipe <= '0;
    else     pipe <= {pipe[0], issue};
  end

  // Sequencer: address walk, END/abort handling, busy and done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      addr_er  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      end_seen <= 1'b0;
    end else begin
      done <= 1'b0;
      if (issue) addr_er <= addr_er + ADDRW'(1);
      unique case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            addr_er  <= start_addr;
            end_seen <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (abort) begin
            state <= ST_ABORT;
          end else if (land_end) begin
            end_seen <= 1'b1;
            state    <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (abort) begin
            state <= ST_ABORT;
          end else if (inflight == 2'd0 && fifo_empty) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_ABORT: begin
          if (inflight == 2'd0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  a_credit_holds: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));

endmodule

// File: tb/tb_erlist_fetch.sv
// Directed bench for erlist_fetch with a 2-cycle-latency command list model.
// Latency: n/a.
// Backpressure: cmd_ready driven from per-cycle patterns.
module tb_erlist_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  start_addr;
  logic        abort;
  logic [3:0]  addr_er;
  logic [31:0] din_er;
  logic [31:0] cmd;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [16];
  logic [31:0] rd1;

  logic [31:0] got[$];
  int          got_cyc[$];
  int          done_cnt;
  int          done_cyc;
  logic        busy_at_done;
  int          stall_viol;
  logic        valid_seen;

  erlist_fetch #(
    .WORD  (32),
    .ADDRW (4),
    .OPW   (4),
    .FIFOD (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .abort      (abort),
    .addr_er    (addr_er),
    .din_er     (din_er),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Command list RAM: data appears 2 cycles after the address
  always @(posedge clk) begin
    rd1    <= mem[addr_er];
    din_er <= rd1;
  end

  task automatic fill_mem(input logic [31:0] base);
    for (int i = 0; i < 16; i++) mem[i] = base + 32'(i);
  endtask

  task automatic do_start(input logic [3:0] a);
    @(posedge clk); #1;
    start = 1'b1;
    start_addr = a;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Record accepted words, done pulses and stall stability for n cycles
  task automatic collect(input int n, input logic [31:0] rdy_pat);
    logic pv, pr;
    logic [31:0] pc;
    pv = 1'b0; pr = 1'b1; pc = '0;
    got.delete(); got_cyc.delete();
    done_cnt = 0; done_cyc = -1; busy_at_done = 1'b1; stall_viol = 0; valid_seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      cmd_ready = rdy_pat[i % 32];
      if (pv && !pr && (!cmd_valid || cmd !== pc)) stall_viol++;
      if (cmd_valid) valid_seen = 1'b1;
      if (cmd_valid && cmd_ready) begin
        got.push_back(cmd);
        got_cyc.push_back(i);
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = i;
          busy_at_done = busy;
        end
      end
      pv = cmd_valid; pr = cmd_ready; pc = cmd;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start_addr = '0; abort = 1'b0; cmd_ready = 1'b0;
    fill_mem(32'h0);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid: got %b expected 0", cmd_valid); end
    checks++; if (addr_er !== 4'h0) begin errors++; $display("FAIL reset_addr_er: got %h expected 0", addr_er); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] exp [3];
    exp[0] = 32'h10000001; exp[1] = 32'h10000002; exp[2] = 32'h10000003;
    fill_mem(32'h0);
    mem[0] = 32'h10000001; mem[1] = 32'h10000002; mem[2] = 32'h10000003; mem[3] = 32'hF0000000;
    cmd_ready = 1'b1;
    do_start(4'd0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_rise: got %b expected 1", busy); end
    collect(20, 32'hFFFF_FFFF);
    checks++; if (got.size() != 3) begin errors++; $display("FAIL basic_count: got %0d words expected 3", got.size()); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (k >= got.size() || got[k] !== exp[k]) begin
        errors++; $display("FAIL basic_word%0d: got %h expected %h", k, (k < got.size()) ? got[k] : 32'hX, exp[k]);
      end
    end
    checks++;
    if (got_cyc.size() < 3 || got_cyc[0] != 3 || got_cyc[2] - got_cyc[0] != 2) begin
      errors++; $display("FAIL basic_timing: first=%0d last=%0d expected first=3 last=5",
                         (got_cyc.size() > 0) ? got_cyc[0] : -1, (got_cyc.size() > 2) ? got_cyc[2] : -1);
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt); end
    checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL basic_busy_fall: got %b expected 0", busy_at_done); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp [3];
    exp[0] = 32'h10000001; exp[1] = 32'h10000002; exp[2] = 32'h10000003;
    fill_mem(32'h0);
    mem[0] = 32'h10000001; mem[1] = 32'h10000002; mem[2] = 32'h10000003; mem[3] = 32'hF0000000;
    cmd_ready = 1'b0;
    do_start(4'd0);
    collect(60, 32'hB5DB_6C93);
    checks++; if (got.size() != 3) begin errors++; $display("FAIL bp_count: got %0d words expected 3", got.size()); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (k >= got.size() || got[k] !== exp[k]) begin
        errors++; $display("FAIL bp_word%0d: got %h expected %h", k, (k < got.size()) ? got[k] : 32'hX, exp[k]);
      end
    end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalls expected 0", stall_viol); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done_count: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp [3];
    exp[0] = 32'h2000000E; exp[1] = 32'h2000000F; exp[2] = 32'h20000000;
    fill_mem(32'h0);
    mem[14] = 32'h2000000E; mem[15] = 32'h2000000F; mem[0] = 32'h20000000; mem[1] = 32'hF0000000;
    cmd_ready = 1'b1;
    do_start(4'd14);
    collect(20, 32'hFFFF_FFFF);
    checks++; if (got.size() != 3) begin errors++; $display("FAIL wrap_count: got %0d words expected 3", got.size()); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (k >= got.size() || got[k] !== exp[k]) begin
        errors++; $display("FAIL wrap_word%0d: got %h expected %h", k, (k < got.size()) ? got[k] : 32'hX, exp[k]);
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL wrap_done_count: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_prefetch_end();
    fill_mem(32'h0);
    mem[5] = 32'hF0000000; mem[6] = 32'h30000006; mem[7] = 32'h30000007;
    cmd_ready = 1'b1;
    do_start(4'd5);
    collect(16, 32'hFFFF_FFFF);
    checks++; if (valid_seen !== 1'b0) begin errors++; $display("FAIL pf_no_valid: got cmd_valid seen=%b expected 0", valid_seen); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL pf_done_count: got %0d expected 1", done_cnt); end
    checks++; if (done_cyc < 0 || done_cyc > 6) begin errors++; $display("FAIL pf_done_time: got cycle %0d expected <=6", done_cyc); end
  endtask

  task automatic test_abort();
    int dcnt, dk, vbad, idle_done, idle_busy;
    fill_mem(32'h10000000);
    cmd_ready = 1'b0;
    do_start(4'd0);
    repeat (4) begin @(posedge clk); #1; end
    checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL abort_pre_valid: got %b expected 1", cmd_valid); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL abort_flush: got cmd_valid %b expected 0", cmd_valid); end
    dcnt = 0; dk = -1; vbad = 0;
    for (int k = 1; k <= 5; k++) begin
      if (done) begin dcnt++; if (dk < 0) dk = k; end
      if (cmd_valid) vbad++;
      @(posedge clk); #1;
    end
    checks++; if (dcnt != 1 || dk > 3) begin errors++; $display("FAIL abort_done: got %0d pulses at %0d expected 1 within 3", dcnt, dk); end
    checks++; if (vbad != 0) begin errors++; $display("FAIL abort_valid_after: got %0d valid cycles expected 0", vbad); end

    // abort while idle must be ignored
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    idle_done = 0; idle_busy = 0;
    for (int k = 0; k < 4; k++) begin
      if (done) idle_done++;
      if (busy) idle_busy++;
      @(posedge clk); #1;
    end
    checks++; if (idle_done != 0 || idle_busy != 0) begin
      errors++; $display("FAIL abort_idle: got done=%0d busy=%0d expected 0 0", idle_done, idle_busy);
    end

    // restart from 0 with an initial stall so the FIFO fills to its limit
    do_start(4'd0);
    collect(24, 32'hFFFF_FF00);
    checks++; if (got.size() < 8) begin errors++; $display("FAIL restart_count: got %0d words expected >=8", got.size()); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (k >= got.size() || got[k] !== 32'h10000000 + 32'(k)) begin
        errors++; $display("FAIL restart_word%0d: got %h expected %h", k, (k < got.size()) ? got[k] : 32'hX, 32'h10000000 + 32'(k));
      end
    end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL restart_no_done: got %0d expected 0", done_cnt); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (done) dcnt++;
      @(posedge clk); #1;
    end
    checks++; if (dcnt != 1) begin errors++; $display("FAIL restart_abort_done: got %0d expected 1", dcnt); end
  endtask

  task automatic test_reset_mid();
    int dcnt;
    fill_mem(32'h0);
    mem[0] = 32'h10000001; mem[1] = 32'h10000002; mem[2] = 32'h10000003; mem[3] = 32'hF0000000;
    cmd_ready = 1'b0;
    do_start(4'd0);
    repeat (4) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b1 || cmd_valid !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre: got busy=%b valid=%b expected 1 1", busy, cmd_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", cmd_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (addr_er !== 4'h0) begin errors++; $display("FAIL rstmid_addr: got %h expected 0", addr_er); end
    dcnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    checks++; if (dcnt != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", dcnt); end
    test_basic();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_prefetch_end();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
